// File: rtl/pipe_ifetch.sv
// Instruction-fetch front end.
// Issues fetches for the current pc under a credit limit, remembers the pc of
// every in-flight request, buffers returned words in a small FIFO and presents
// the FIFO head to decode. A redirect (flush) kills buffered words and marks
// every still-outstanding response for discard.
//
// Ports:
//   clk, clr        clock; asynchronous active-high reset
//   pc              current program counter (also the fetch address)
//   flush           redirect this cycle; PC register loads the target
//   id_stall        decode cannot take an instruction this cycle
//   imem_req/addr   fetch request and address
//   imem_ready      memory accepts the request
//   imem_rvalid/rdata  in-order response
//   pc_en           PC register advance/load enable
//   ifid_valid/inst/pc  instruction handed to decode (NOP/0 when invalid)
module pipe_ifetch #(
  parameter int unsigned DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        pc_en,
  output logic        ifid_valid,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DepthOcc = (CW + 1)'(DEPTH);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] out_q, out_d;    // requests accepted, response not yet seen
  logic [CW-1:0] cnt_q, cnt_d;    // words buffered in the FIFO
  logic [CW-1:0] disc_q, disc_d;  // outstanding responses to throw away
  logic [AW-1:0] pend_wr_q, pend_rd_q;
  logic [AW-1:0] fifo_wr_q, fifo_rd_q;
  logic [31:0]   pend_pc_q   [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_inst_q [DEPTH];

  logic [CW:0] occ;
  logic        issue, resp, keep, pop;

  assign imem_addr = pc;

  always_comb begin
    state_d    = state_q;
    occ        = {1'b0, out_q} + {1'b0, cnt_q};
    imem_req   = 1'b0;
    issue      = 1'b0;
    resp       = 1'b0;
    keep       = 1'b0;
    pop        = 1'b0;
    pc_en      = 1'b0;
    ifid_valid = 1'b0;
    ifid_inst  = NOP;
    ifid_pc    = 32'h0;
    out_d      = out_q;
    cnt_d      = cnt_q;
    disc_d     = disc_q;

    if (state_q == StBoot) state_d = StRun;

    // Credit counts buffered plus in-flight words so a response always has a slot.
    imem_req = (state_q == StRun) && !flush && (occ < DepthOcc);
    issue    = imem_req && imem_ready;
    // Responses with nothing outstanding (e.g. left over from before reset) are ignored.
    resp     = imem_rvalid && (out_q != '0);
    keep     = resp && (disc_q == '0) && !flush;
    pc_en    = !clr && (issue || flush);

    ifid_valid = (cnt_q != '0) && !flush;
    if (ifid_valid) begin
      ifid_inst = fifo_inst_q[fifo_rd_q];
      ifid_pc   = fifo_pc_q[fifo_rd_q];
    end
    pop = ifid_valid && !id_stall;

    out_d = out_q + CW'(issue) - CW'(resp);

    if (flush) begin
      // Everything still in flight after this cycle belongs to the old path.
      disc_d = out_q - CW'(resp);
      cnt_d  = '0;
    end else begin
      if (resp && (disc_q != '0)) disc_d = disc_q - CW'(1);
      cnt_d = cnt_q + CW'(keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= StBoot;
      out_q     <= '0;
      cnt_q     <= '0;
      disc_q    <= '0;
      pend_wr_q <= '0;
      pend_rd_q <= '0;
      fifo_wr_q <= '0;
      fifo_rd_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      disc_q  <= disc_d;
      if (issue) pend_wr_q <= pend_wr_q + AW'(1);
      if (resp)  pend_rd_q <= pend_rd_q + AW'(1);
      if (flush) begin
        fifo_wr_q <= '0;
        fifo_rd_q <= '0;
      end else begin
        if (keep) fifo_wr_q <= fifo_wr_q + AW'(1);
        if (pop)  fifo_rd_q <= fifo_rd_q + AW'(1);
      end
    end
  end

  // Storage needs no reset: pointers and counters gate every read.
  always_ff @(posedge clk) begin
    if (issue) pend_pc_q[pend_wr_q] <= pc;
    if (keep) begin
      fifo_pc_q[fifo_wr_q]   <= pend_pc_q[pend_rd_q];
      fifo_inst_q[fifo_wr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_pipe_ifetch.sv
// Bench for pipe_ifetch: models the PC register and a 1-cycle in-order memory,
// keeps a queue of expected (pc, inst) pairs and checks decode-side output.
module tb_pipe_ifetch;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk, clr, flush, id_stall;
  logic [31:0] pc;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        pc_en, ifid_valid;
  logic [31:0] ifid_inst, ifid_pc;

  pipe_ifetch #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk        (clk),
    .clr        (clr),
    .pc         (pc),
    .flush      (flush),
    .id_stall   (id_stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .pc_en      (pc_en),
    .ifid_valid (ifid_valid),
    .ifid_inst  (ifid_inst),
    .ifid_pc    (ifid_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  int total = 0;
  int bad   = 0;
  int issues = 0;

  // stimulus knobs, applied at the next falling edge
  logic        k_clr, k_flush, k_stall, k_ready, k_hold, k_spur;
  logic [31:0] k_target;

  logic [31:0] mem_q [$];
  ent_t        exp_q [$];

  // outputs sampled mid-cycle
  logic        s_req, s_en, s_valid;
  logic [31:0] s_addr, s_inst, s_ipc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    ent_t        e;
    logic        iss, from_q, en, fl;
    logic [31:0] iss_addr;
    @(negedge clk);
    clr        = k_clr;
    flush      = k_flush;
    id_stall   = k_stall;
    imem_ready = k_ready;
    if (k_clr) begin
      mem_q.delete();
      exp_q.delete();
      pc = 32'h0;
    end
    from_q = !k_hold && (mem_q.size() > 0);
    if (from_q) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0]);
    end else if (k_spur) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0BAD_0BAD;
    end
    #1;
    s_req   = imem_req;
    s_en    = pc_en;
    s_valid = ifid_valid;
    s_addr  = imem_addr;
    s_inst  = ifid_inst;
    s_ipc   = ifid_pc;
    if (ifid_valid && !id_stall) begin
      e = '1;  // unaligned sentinel: an unexpected pop cannot match it
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("sb_pc", ifid_pc, e.pc);
      check("sb_inst", ifid_inst, e.inst);
    end
    if (flush) exp_q.delete();
    iss      = imem_req && imem_ready;
    iss_addr = pc;
    if (iss) begin
      issues++;
      exp_q.push_back({pc, mem_word(pc)});
    end
    en = pc_en;
    fl = flush;
    @(posedge clk);
    #1;
    if (from_q) void'(mem_q.pop_front());
    if (iss) mem_q.push_back(iss_addr);
    if (en) pc = fl ? k_target : pc + 32'd4;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(s_req), 32'd0);
    check({tag, "_pc_en"}, 32'(s_en), 32'd0);
    check({tag, "_valid"}, 32'(s_valid), 32'd0);
    check({tag, "_inst"}, s_inst, NOP);
    check({tag, "_ifid_pc"}, s_ipc, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    logic        found;
    clr = 1'b1; flush = 1'b0; id_stall = 1'b0; imem_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; pc = 32'h0;
    k_clr = 1'b1; k_flush = 1'b0; k_stall = 1'b0; k_ready = 1'b1;
    k_hold = 1'b0; k_spur = 1'b0; k_target = 32'h0;

    // Power-on reset
    repeat (2) cycle();
    check_reset_outputs("por");

    // Back-to-back stream from pc 0
    k_clr = 1'b0;
    cycle();
    check("boot_no_req", 32'(s_req), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("stream_pc_en", 32'(s_en), 32'd1);
      if (i >= 2) check("stream_valid", 32'(s_valid), 32'd1);
      if (i >= 2 && i <= 4) begin
        check("stream_ifid_pc", s_ipc, 32'(4 * (i - 2)));
        check("stream_ifid_inst", s_inst, mem_word(32'(4 * (i - 2))));
      end
    end

    // Reset mid-run: outputs drop in the same cycle
    k_clr = 1'b1;
    k_stall = 1'b1;
    cycle();
    check_reset_outputs("midrun_clr");
    k_clr = 1'b0;
    cycle();
    check("post_clr_boot_req", 32'(s_req), 32'd0);

    // Decode stalled from empty: exactly DEPTH fetches, then hold
    issues = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 0) begin
        check("post_clr_req", 32'(s_req), 32'd1);
        check("post_clr_addr", s_addr, 32'h0);
      end
    end
    check("stall_issues", 32'(issues), 32'(DEPTH));
    check("stall_req", 32'(s_req), 32'd0);
    check("stall_pc_en", 32'(s_en), 32'd0);
    check("stall_valid", 32'(s_valid), 32'd1);
    k_stall = 1'b0;
    repeat (6) cycle();

    // Memory not ready: request held with a stable address
    k_ready = 1'b0;
    held = pc;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("notready_req", 32'(s_req), 32'd1);
      check("notready_addr", s_addr, held);
      check("notready_pc_en", 32'(s_en), 32'd0);
    end
    repeat (5) cycle();
    check("drain_valid", 32'(s_valid), 32'd0);
    check("drain_nothing_lost", 32'(exp_q.size()), 32'd0);

    // Two requests in flight, then redirect to 0x100
    k_ready = 1'b1;
    k_hold  = 1'b1;
    issues  = 0;
    repeat (2) cycle();
    check("flush_pre_issues", 32'(issues), 32'd2);
    k_hold   = 1'b0;
    k_flush  = 1'b1;
    k_target = 32'h100;
    cycle();
    check("flush_valid", 32'(s_valid), 32'd0);
    check("flush_req", 32'(s_req), 32'd0);
    check("flush_pc_en", 32'(s_en), 32'd1);
    k_flush = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      found = s_valid;
    end
    check("flush_target_seen", 32'(found), 32'd1);
    check("flush_target_pc", s_ipc, 32'h100);
    check("flush_target_inst", s_inst, mem_word(32'h100));

    // Stray response with nothing outstanding
    k_ready = 1'b0;
    repeat (6) cycle();
    check("idle_valid", 32'(s_valid), 32'd0);
    k_spur = 1'b1;
    cycle();
    check("spur_valid_same", 32'(s_valid), 32'd0);
    k_spur = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("spur_ignored", 32'(s_valid), 32'd0);
    end
    check("spur_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
